// File: rtl/reg_file_rename.sv
// Architectural register file with rename table (busy/tag per register) and operand bypass.
// Optional rename-state checkpoints are compiled in when RF_CKPT_EN is defined.
module reg_file_rename #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int TW    = 5,
    parameter int NRP   = 2,
    parameter int NCDB  = 2,
    parameter int NCKPT = 4,
    parameter int CW    = $clog2(NCKPT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic [NRP*AW-1:0]   rd_idx,
    output logic [NRP*32-1:0]   rd_val,
    output logic [NRP-1:0]      rd_ok,
    output logic [NRP*TW-1:0]   rob_q_tag,
    input  logic [NRP-1:0]      rob_q_ok,
    input  logic [NRP*32-1:0]   rob_q_val,
    input  logic                cmt_v,
    input  logic [AW-1:0]       cmt_rd,
    input  logic [TW-1:0]       cmt_tag,
    input  logic [31:0]         cmt_val,
    input  logic                rnm_v,
    input  logic [AW-1:0]       rnm_rd,
    input  logic [TW-1:0]       rnm_tag,
    input  logic [NCDB-1:0]     cdb_v,
    input  logic [NCDB*TW-1:0]  cdb_tag,
    input  logic [NCDB*32-1:0]  cdb_val,
    input  logic                ckpt_save,
    input  logic [CW-1:0]       ckpt_wid,
    input  logic                ckpt_rst,
    input  logic [CW-1:0]       ckpt_rid
);

    logic [NREG-1:0] busy_reg, busy_next;
    logic [TW-1:0]   tag_reg  [NREG];
    logic [TW-1:0]   tag_next [NREG];
    logic [31:0]     val_reg  [NREG];
    logic [31:0]     val_next [NREG];
    logic            restore;

`ifdef RF_CKPT_EN
    logic [NREG-1:0] ckpt_busy_reg  [NCKPT];
    logic [NREG-1:0] ckpt_busy_next [NCKPT];
    logic [TW-1:0]   ckpt_tag_reg   [NCKPT][NREG];
    logic [TW-1:0]   ckpt_tag_next  [NCKPT][NREG];

    assign restore = ckpt_rst;
`else
    logic ckpt_unused;

    assign restore     = 1'b0;
    assign ckpt_unused = ^{ckpt_save, ckpt_wid, ckpt_rst, ckpt_rid};
`endif

    // Live rename state: flush wins, a restore replaces the image before commit applies.
    always_comb begin
        busy_next = busy_reg;
        tag_next  = tag_reg;
        val_next  = val_reg;
        if (flush) begin
            busy_next = '0;
            for (int i = 0; i < NREG; i++) begin
                tag_next[i] = '0;
            end
        end else begin
`ifdef RF_CKPT_EN
            if (restore) begin
                busy_next = ckpt_busy_reg[ckpt_rid];
                tag_next  = ckpt_tag_reg[ckpt_rid];
            end
`endif
            if (cmt_v) begin
                val_next[cmt_rd] = cmt_val;
                if (busy_next[cmt_rd] && (tag_next[cmt_rd] == cmt_tag)) begin
                    busy_next[cmt_rd] = 1'b0;
                    tag_next[cmt_rd]  = '0;
                end
            end
            if (rnm_v && !restore) begin
                busy_next[rnm_rd] = 1'b1;
                tag_next[rnm_rd]  = rnm_tag;
            end
        end
        busy_next[0] = 1'b0;
        tag_next[0]  = '0;
        val_next[0]  = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
            for (int i = 0; i < NREG; i++) begin
                tag_reg[i] <= '0;
                val_reg[i] <= '0;
            end
        end else if (rdy) begin
            busy_reg <= busy_next;
            tag_reg  <= tag_next;
            val_reg  <= val_next;
        end
    end

`ifdef RF_CKPT_EN
    // Commits retire matching entries in every snapshot; a save captures the post-update image.
    always_comb begin
        ckpt_busy_next = ckpt_busy_reg;
        ckpt_tag_next  = ckpt_tag_reg;
        if (!flush && cmt_v) begin
            for (int s = 0; s < NCKPT; s++) begin
                if (ckpt_busy_reg[s][cmt_rd] && (ckpt_tag_reg[s][cmt_rd] == cmt_tag)) begin
                    ckpt_busy_next[s][cmt_rd] = 1'b0;
                    ckpt_tag_next[s][cmt_rd]  = '0;
                end
            end
        end
        if (ckpt_save) begin
            ckpt_busy_next[ckpt_wid] = busy_next;
            ckpt_tag_next[ckpt_wid]  = tag_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NCKPT; s++) begin
                ckpt_busy_reg[s] <= '0;
                for (int i = 0; i < NREG; i++) begin
                    ckpt_tag_reg[s][i] <= '0;
                end
            end
        end else if (rdy) begin
            ckpt_busy_reg <= ckpt_busy_next;
            ckpt_tag_reg  <= ckpt_tag_next;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NRP; gi++) begin : g_port
            logic [AW-1:0] idx;
            logic [TW-1:0] cur_tag;
            logic          cdb_hit;
            logic [31:0]   cdb_hit_val;
            logic          ok_p;
            logic [31:0]   val_p;

            assign idx     = rd_idx[gi*AW +: AW];
            assign cur_tag = tag_reg[idx];

            // Scan downwards so the lowest matching channel is the one left standing.
            always_comb begin
                cdb_hit     = 1'b0;
                cdb_hit_val = '0;
                for (int c = NCDB - 1; c >= 0; c--) begin
                    if (cdb_v[c] && (cdb_tag[c*TW +: TW] == cur_tag)) begin
                        cdb_hit     = 1'b1;
                        cdb_hit_val = cdb_val[c*32 +: 32];
                    end
                end
            end

            always_comb begin
                ok_p  = 1'b1;
                val_p = val_reg[idx];
                if (busy_reg[idx]) begin
                    if (rob_q_ok[gi]) begin
                        val_p = rob_q_val[gi*32 +: 32];
                    end else if (cdb_hit) begin
                        val_p = cdb_hit_val;
                    end else if (cmt_v && (cmt_tag == cur_tag)) begin
                        val_p = cmt_val;
                    end else begin
                        ok_p  = 1'b0;
                        val_p = {{(32-TW){1'b0}}, cur_tag};
                    end
                end
            end

            assign rd_ok[gi]              = ok_p;
            assign rd_val[gi*32 +: 32]    = val_p;
            assign rob_q_tag[gi*TW +: TW] = cur_tag;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed bench for reg_file_rename: per-register model checked every cycle plus pinned literals.
module tb_reg_file_rename;
    localparam int NREG = 32, AW = 5, TW = 5, NRP = 2, NCDB = 2, NCKPT = 4, CW = 2;

    logic                clk = 1'b0;
    logic                rst, rdy, flush;
    logic [NRP*AW-1:0]   rd_idx;
    logic [NRP*32-1:0]   rd_val;
    logic [NRP-1:0]      rd_ok;
    logic [NRP*TW-1:0]   rob_q_tag;
    logic [NRP-1:0]      rob_q_ok;
    logic [NRP*32-1:0]   rob_q_val;
    logic                cmt_v;
    logic [AW-1:0]       cmt_rd;
    logic [TW-1:0]       cmt_tag;
    logic [31:0]         cmt_val;
    logic                rnm_v;
    logic [AW-1:0]       rnm_rd;
    logic [TW-1:0]       rnm_tag;
    logic [NCDB-1:0]     cdb_v;
    logic [NCDB*TW-1:0]  cdb_tag;
    logic [NCDB*32-1:0]  cdb_val;
    logic                ckpt_save, ckpt_rst;
    logic [CW-1:0]       ckpt_wid, ckpt_rid;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    reg_file_rename #(.NREG(NREG), .AW(AW), .TW(TW), .NRP(NRP), .NCDB(NCDB), .NCKPT(NCKPT)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .rd_idx(rd_idx), .rd_val(rd_val), .rd_ok(rd_ok),
        .rob_q_tag(rob_q_tag), .rob_q_ok(rob_q_ok), .rob_q_val(rob_q_val),
        .cmt_v(cmt_v), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_val(cmt_val),
        .rnm_v(rnm_v), .rnm_rd(rnm_rd), .rnm_tag(rnm_tag),
        .cdb_v(cdb_v), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .ckpt_save(ckpt_save), .ckpt_wid(ckpt_wid), .ckpt_rst(ckpt_rst), .ckpt_rid(ckpt_rid)
    );

    always #5 clk = ~clk;

    // Model: what each architectural register holds and which tag it waits on.
    logic [31:0] m_val  [NREG];
    bit          m_busy [NREG];
    int          m_tag  [NREG];
    bit          m_ck_busy [NCKPT][NREG];
    int          m_ck_tag  [NCKPT][NREG];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit o_busy [NCKPT][NREG];
        int o_tag  [NCKPT][NREG];
        bit do_restore;
        o_busy = m_ck_busy;
        o_tag  = m_ck_tag;
        do_restore = 1'b0;
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                m_val[r] = 0; m_busy[r] = 0; m_tag[r] = 0;
                for (int s = 0; s < NCKPT; s++) begin
                    m_ck_busy[s][r] = 0; m_ck_tag[s][r] = 0;
                end
            end
        end else if (rdy) begin
            if (flush) begin
                for (int r = 0; r < NREG; r++) begin
                    m_busy[r] = 0; m_tag[r] = 0;
                end
            end else begin
`ifdef RF_CKPT_EN
                if (ckpt_rst) begin
                    do_restore = 1'b1;
                    for (int r = 0; r < NREG; r++) begin
                        m_busy[r] = o_busy[ckpt_rid][r];
                        m_tag[r]  = o_tag[ckpt_rid][r];
                    end
                end
`endif
                if (cmt_v && cmt_rd != 0) begin
                    m_val[cmt_rd] = cmt_val;
                    if (m_busy[cmt_rd] && m_tag[cmt_rd] == int'(cmt_tag)) begin
                        m_busy[cmt_rd] = 0; m_tag[cmt_rd] = 0;
                    end
                end
                if (rnm_v && !do_restore && rnm_rd != 0) begin
                    m_busy[rnm_rd] = 1; m_tag[rnm_rd] = int'(rnm_tag);
                end
            end
`ifdef RF_CKPT_EN
            if (!flush && cmt_v) begin
                for (int s = 0; s < NCKPT; s++) begin
                    if (m_ck_busy[s][cmt_rd] && m_ck_tag[s][cmt_rd] == int'(cmt_tag)) begin
                        m_ck_busy[s][cmt_rd] = 0; m_ck_tag[s][cmt_rd] = 0;
                    end
                end
            end
            if (ckpt_save) begin
                for (int r = 0; r < NREG; r++) begin
                    m_ck_busy[ckpt_wid][r] = m_busy[r];
                    m_ck_tag[ckpt_wid][r]  = m_tag[r];
                end
            end
`endif
        end
    endtask

    always @(posedge clk) model_step();

    // Operand read rule applied to the model state and the current bypass inputs.
    task automatic model_read(input int p, output logic ok, output logic [31:0] v, output logic [31:0] t);
        int  r;
        bit  found;
        r = int'(rd_idx[p*AW +: AW]);
        t = 32'(m_tag[r]);
        ok = 1'b1;
        v = m_val[r];
        found = 1'b0;
        if (m_busy[r]) begin
            if (rob_q_ok[p]) begin
                v = rob_q_val[p*32 +: 32];
            end else begin
                for (int c = 0; c < NCDB; c++) begin
                    if (!found && cdb_v[c] && int'(cdb_tag[c*TW +: TW]) == m_tag[r]) begin
                        found = 1'b1;
                        v = cdb_val[c*32 +: 32];
                    end
                end
                if (!found) begin
                    if (cmt_v && int'(cmt_tag) == m_tag[r]) v = cmt_val;
                    else begin ok = 1'b0; v = 32'(m_tag[r]); end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int p = 0; p < NRP; p++) begin
                logic ok_e;
                logic [31:0] v_e, t_e;
                model_read(p, ok_e, v_e, t_e);
                chk($sformatf("model_ok%0d", p), 32'(rd_ok[p]), 32'(ok_e));
                chk($sformatf("model_val%0d", p), rd_val[p*32 +: 32], v_e);
                chk($sformatf("model_tag%0d", p), 32'(rob_q_tag[p*TW +: TW]), t_e);
            end
            $display("cycle t=%0t idx=%h ok=%b val=%h_%h", $time, rd_idx, rd_ok, rd_val[63:32], rd_val[31:0]);
        end
    end

    task automatic clear();
        rdy = 1'b1; flush = 1'b0; rd_idx = '0;
        rob_q_ok = '0; rob_q_val = '0;
        cmt_v = 1'b0; cmt_rd = '0; cmt_tag = '0; cmt_val = '0;
        rnm_v = 1'b0; rnm_rd = '0; rnm_tag = '0;
        cdb_v = '0; cdb_tag = '0; cdb_val = '0;
        ckpt_save = 1'b0; ckpt_wid = '0; ckpt_rst = 1'b0; ckpt_rid = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        clear();
    endtask

    task automatic set_rd(input int a, input int b);
        rd_idx = {AW'(b), AW'(a)};
    endtask

    task automatic rename(input int r, input int t);
        rnm_v = 1'b1; rnm_rd = AW'(r); rnm_tag = TW'(t);
    endtask

    task automatic commit(input int r, input int t, input logic [31:0] v);
        cmt_v = 1'b1; cmt_rd = AW'(r); cmt_tag = TW'(t); cmt_val = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;

        set_rd(5, 5);
        @(negedge clk);
        chk("reset_ok", 32'(rd_ok), 32'h3);
        chk("reset_val0", rd_val[31:0], 32'h0);
        chk("reset_val1", rd_val[63:32], 32'h0);
        next();

        set_rd(5, 5); rename(5, 3);
        @(negedge clk);
        chk("rename_invisible", 32'(rd_ok), 32'h3);
        next();

        set_rd(5, 5);
        @(negedge clk);
        chk("busy_ok", 32'(rd_ok), 32'h0);
        chk("busy_tagval", rd_val[31:0], 32'h3);
        chk("busy_robq", 32'(rob_q_tag[TW-1:0]), 32'h3);
        next();

        set_rd(5, 5);
        cdb_v = 2'b11; cdb_tag = {TW'(3), TW'(3)}; cdb_val = {32'hB, 32'hA};
        rob_q_ok = 2'b10; rob_q_val = {32'h77, 32'h0};
        @(negedge clk);
        chk("cdb_lowest", rd_val[31:0], 32'hA);
        chk("robq_first", rd_val[63:32], 32'h77);
        next();

        set_rd(5, 5); commit(5, 3, 32'h5A);
        cdb_v = 2'b10; cdb_tag = {TW'(4), TW'(0)}; cdb_val = {32'hB, 32'h0};
        @(negedge clk);
        chk("cmt_bypass", rd_val[31:0], 32'h5A);
        next();

        set_rd(5, 5);
        @(negedge clk);
        chk("cmt_retired", rd_val[31:0], 32'h5A);
        next();

        rename(7, 4); next();
        commit(7, 4, 32'h55); next();
        set_rd(7, 0);
        @(negedge clk);
        chk("x7_ok", 32'(rd_ok), 32'h3);
        chk("x7_val", rd_val[31:0], 32'h55);
        next();

        rename(7, 6); next();
        commit(7, 2, 32'h99); next();
        set_rd(7, 7);
        @(negedge clk);
        chk("stale_busy", 32'(rd_ok), 32'h0);
        chk("stale_tag", rd_val[31:0], 32'h6);
        next();

        commit(9, 1, 32'h11); rename(9, 6); next();
        set_rd(9, 9);
        @(negedge clk);
        chk("rnm_over_cmt_ok", 32'(rd_ok), 32'h0);
        chk("rnm_over_cmt_tag", rd_val[31:0], 32'h6);
        next();

        commit(3, 0, 32'h33); next();
        rename(3, 5); next();
        rename(0, 2); next();
        set_rd(0, 3);
        @(negedge clk);
        chk("x0_ok", 32'(rd_ok), 32'h1);
        chk("x0_val", rd_val[31:0], 32'h0);
        flush = 1'b1; rename(12, 7);
        next();

        set_rd(3, 7);
        @(negedge clk);
        chk("flush_ok", 32'(rd_ok), 32'h3);
        chk("flush_x3", rd_val[31:0], 32'h33);
        chk("flush_x7", rd_val[63:32], 32'h99);
        next();

        set_rd(9, 12);
        @(negedge clk);
        chk("flush_x9", rd_val[31:0], 32'h11);
        chk("flush_drop_rnm", 32'(rd_ok), 32'h3);
        next();

        rdy = 1'b0; rename(10, 7); next();
        set_rd(10, 10);
        @(negedge clk);
        chk("hold_ok", 32'(rd_ok), 32'h3);
        next();

`ifdef RF_CKPT_EN
        rename(4, 2); next();
        ckpt_save = 1'b1; ckpt_wid = 2'd1; next();
        rename(4, 5); next();
        commit(4, 2, 32'h44); next();
        set_rd(4, 4);
        @(negedge clk);
        chk("ckpt_live_busy", 32'(rd_ok), 32'h0);
        chk("ckpt_live_tag", rd_val[31:0], 32'h5);
        ckpt_rst = 1'b1; ckpt_rid = 2'd1;
        next();
        set_rd(4, 4);
        @(negedge clk);
        chk("ckpt_restore_ok", 32'(rd_ok), 32'h3);
        chk("ckpt_restore_val", rd_val[31:0], 32'h44);
        next();
`endif

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
